// File: rtl/edge_bitmap_streamer.sv
// Snapshots a packed edge bitmap on start and streams it out as 8-bit pixels
// in raster order over a valid/ready handshake, with frame and line markers.
module edge_bitmap_streamer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  FG    = 8'hFF,
    parameter logic [7:0]  BG    = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH*DEPTH:0]   bitmap,
    input  logic                   start,
    input  logic                   invert,
    output logic [7:0]             pixel_out,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic                   sof,
    output logic                   eol,
    output logic                   eof,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned N  = WIDTH * DEPTH;
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t          state;
    logic [N-2:0]    snap;      // pixels still to come after the one on pixel_out
    logic            inv;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            last_x;
    logic            last_y;
    logic            xfer;
    logic            unused_top;

    assign last_x     = (x == XW'(WIDTH - 1));
    assign last_y     = (y == YW'(DEPTH - 1));
    assign xfer       = pixel_valid & pixel_ready;
    assign unused_top = bitmap[N];

    assign sof = pixel_valid & (x == '0) & (y == '0);
    assign eol = pixel_valid & last_x;
    assign eof = pixel_valid & last_x & last_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            snap        <= '0;
            inv         <= 1'b0;
            x           <= '0;
            y           <= '0;
            pixel_out   <= 8'h00;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap        <= bitmap[N-1:1];
                        inv         <= invert;
                        x           <= '0;
                        y           <= '0;
                        pixel_out   <= (bitmap[0] ^ invert) ? FG : BG;
                        pixel_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last_x && last_y) begin
                            pixel_valid <= 1'b0;
                            pixel_out   <= 8'h00;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            // Shift the snapshot so the next pixel is always at bit 0
                            snap      <= {1'b0, snap[N-2:1]};
                            pixel_out <= (snap[0] ^ inv) ? FG : BG;
                            if (last_x) begin
                                x <= '0;
                                y <= y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    x     <= '0;
                    y     <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edge_bitmap_streamer.sv
// Scoreboard bench for edge_bitmap_streamer on a 4x3 frame.
module tb_edge_bitmap_streamer;
    localparam int unsigned W = 4;
    localparam int unsigned D = 3;
    localparam int unsigned N = W * D;

    logic         clk = 1'b0;
    logic         rst, start, invert, pixel_ready;
    logic [N:0]   bitmap;
    logic [7:0]   pixel_out;
    logic         pixel_valid, sof, eol, eof, busy, done;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   exp_done_cyc = -1;

    // Top bit set to show it is ignored.
    localparam logic [N:0] BMA = {1'b1, 12'b1000_0110_0001};
    localparam logic [N:0] BMB = {1'b0, 12'b0101_0101_0101};

    logic [7:0] tab_a [N] = '{8'hFF, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'hFF, 8'hFF, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] tab_b [N] = '{8'hFF, 8'h00, 8'hFF, 8'h00,
                              8'hFF, 8'h00, 8'hFF, 8'h00,
                              8'hFF, 8'h00, 8'hFF, 8'h00};

    edge_bitmap_streamer #(.WIDTH(W), .DEPTH(D), .FG(8'hFF), .BG(8'h00)) dut (
        .clk(clk), .rst(rst), .bitmap(bitmap), .start(start), .invert(invert),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented pixel with the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_pixel", {pixel_out, sof, eol, eof}, 32'hFFFFFFFF);
                end else begin
                    chk("pixel_markers", {pixel_out, sof, eol, eof},
                        {q[0].pix, q[0].sof, q[0].eol, q[0].eof});
                    if (pixel_ready) void'(q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_cycle", cyc, exp_done_cyc);
            end
        end
    end

    task automatic start_frame(input logic [N:0] bm, input logic inv, input bit use_b);
        exp_t e;
        logic [7:0] p;
        bitmap = bm;
        invert = inv;
        start  = 1'b1;
        step();
        start  = 1'b0;
        exp_done_cyc = cyc + N;
        for (int i = 0; i < N; i++) begin
            p = use_b ? tab_b[i] : tab_a[i];
            e.pix = inv ? ~p : p;
            e.sof = (i == 0);
            e.eol = ((i % W) == W - 1);
            e.eof = (i == N - 1);
            q.push_back(e);
        end
        chk("busy_after_start", {busy, pixel_valid}, 2'b11);
    endtask

    task automatic finish_frame(input string nm, input int exp_dones);
        int n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk({nm, "_timeout"}, 1, 0);
        chk({nm, "_done_count"}, done_cnt, exp_dones);
        chk({nm, "_idle"}, {pixel_valid, busy, done, pixel_out}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; invert = 1'b0; pixel_ready = 1'b1; bitmap = '0;
        repeat (3) step();
        chk("reset_outputs", {pixel_out, pixel_valid, sof, eol, eof, busy, done}, 0);
        rst = 1'b0;
        step();

        // Full-throughput frame
        start_frame(BMA, 1'b0, 1'b0);
        finish_frame("s1", 1);

        // Backpressure at pixel (2,1)
        start_frame(BMA, 1'b0, 1'b0);
        exp_done_cyc += 3;
        repeat (6) step();
        chk("s2_stall_pixel", pixel_out, 8'hFF);
        pixel_ready = 1'b0;
        repeat (3) step();
        pixel_ready = 1'b1;
        finish_frame("s2", 2);

        // Start while busy plus bitmap change mid-frame
        start_frame(BMA, 1'b0, 1'b0);
        repeat (4) step();
        start = 1'b1;
        bitmap = '1;
        step();
        start = 1'b0;
        finish_frame("s3", 3);
        bitmap = BMA;

        // Invert
        start_frame(BMA, 1'b1, 1'b0);
        finish_frame("s4", 4);

        // Reset mid-frame
        start_frame(BMA, 1'b0, 1'b0);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_reset_outputs", {pixel_out, pixel_valid, sof, eol, eof, busy, done}, 0);
        q.delete();
        exp_done_cyc = -1;
        repeat (3) step();
        chk("s5_no_done", done_cnt, 4);
        start_frame(BMA, 1'b0, 1'b0);
        finish_frame("s5", 5);

        // Back-to-back: start in DONE ignored, start in IDLE accepted
        start_frame(BMA, 1'b0, 1'b0);
        repeat (12) step();
        chk("s6_done_state", {done, busy, pixel_valid}, 3'b110);
        bitmap = BMB;
        start = 1'b1;
        step();
        chk("s6_start_ignored", {pixel_valid, busy}, 2'b00);
        start_frame(BMB, 1'b0, 1'b1);
        chk("s6_sof_first", sof, 1'b1);
        finish_frame("s6", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/edge_bitmap_streamer.md
Name: edge_bitmap_streamer

Overview:
- Reader side of the edge-detector output. Takes the packed WIDTH*DEPTH edge bitmap from the Sobel stage and snapshots it on a start pulse.
- Streams the bitmap back out as 8-bit grayscale pixels, one per accepted transfer, in raster order. Bit index is Y*WIDTH+X; X is the fast index.
- Drives the BMP writer or display path through a valid/ready handshake, with frame and line markers.

Parameters:
- WIDTH, 8, image width in pixels (>=2)
- DEPTH, 8, image height in rows (>=2)
- FG, 8'hFF, pixel value emitted for an edge bit (1)
- BG, 8'h00, pixel value emitted for a non-edge bit (0)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bitmap  input  WIDTH*DEPTH+1  packed edge bitmap; bit Y*WIDTH+X = pixel (X,Y); top bit ignored
- start  input  1  request to snapshot bitmap and stream one frame
- invert  input  1  sampled with start; 1 swaps FG/BG for the whole frame
- pixel_out  output  8  current pixel value
- pixel_valid  output  1  pixel_out/markers valid
- pixel_ready  input  1  downstream accepts; transfer = pixel_valid & pixel_ready
- sof  output  1  high with pixel (0,0)
- eol  output  1  high with any pixel where X=WIDTH-1
- eof  output  1  high with pixel (WIDTH-1,DEPTH-1)
- busy  output  1  high in STREAM and DONE
- done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; x=0, y=0; snapshot register cleared; invert flag=0. All outputs are 0: pixel_out, pixel_valid, sof, eol, eof, busy, done.
- Reset mid-frame: outputs are 0 after the reset edge, the in-flight frame is abandoned, and no done pulse is generated.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 latches bitmap into the internal snapshot, latches invert, sets x=0, y=0, and moves to STREAM.
  - Start-to-first-valid latency is 1 cycle: pixel_valid=1 with pixel (0,0) on the cycle after start is sampled.
- STREAM:
  - pixel_valid=1 continuously.
  - pixel_out = (snap[y*WIDTH+x] XOR invert_flag) ? FG : BG.
  - sof, eol and eof are combinational from x/y and gated by pixel_valid.
- Handshake:
  - While pixel_valid & !pixel_ready, pixel_out and all markers hold stable.
  - Each transfer advances the position one step per cycle, so a sustained pixel_ready=1 gives 1 pixel/clk.
  - pixel_valid must never drop in STREAM before the last transfer.
- Position update on transfer:
  - If x<WIDTH-1, x++.
  - Otherwise x=0 and y++.
  - On the transfer of (WIDTH-1,DEPTH-1), move to DONE; no wrap into a new frame.
- DONE: lasts exactly one cycle. pixel_valid=0, done=1, busy=1. The next state is IDLE.
- start outside IDLE (in STREAM or DONE) is ignored: no re-snapshot and no restart. start is accepted again only in IDLE.
- Changes on the bitmap input after the snapshot have no effect on the current frame.
- Frame length is exactly WIDTH*DEPTH transfers. The cycle count is WIDTH*DEPTH + stall cycles, plus 1 cycle for DONE.
- Counter widths: x is clog2(WIDTH) bits and y is clog2(DEPTH) bits; neither may overflow at legal values.
- Simultaneous start and rst: rst wins.

Test Plan:
- Scenario 1, full-throughput frame.
  - Stimulus: WIDTH=4, DEPTH=3, bitmap bits[11:0]=12'b1000_0110_0001, invert=0, ready=1; pulse start.
  - Required response: 12 consecutive valid cycles with pixels FF,00,00,00, 00,FF,FF,00, 00,00,00,FF. sof on the 1st pixel, eol on the 4th/8th/12th, eof on the 12th, done on the 13th cycle, then idle.
- Scenario 2, backpressure.
  - Stimulus: same frame; drop ready for 3 cycles at pixel (2,1).
  - Required response: pixel_out=FF and markers held for 3 cycles; stream resumes with no pixel dropped or duplicated; done lands 3 cycles later than in scenario 1.
- Scenario 3, start while busy.
  - Stimulus: pulse start again at the 5th pixel, and change bitmap to all-ones mid-frame.
  - Required response: output identical to scenario 1; exactly one done pulse.
- Scenario 4, invert.
  - Stimulus: invert=1 at start, same bitmap.
  - Required response: every value swapped (00,FF,FF,FF,...).
- Scenario 5, reset mid-frame.
  - Stimulus: rst=1 for 1 cycle at pixel 6.
  - Required response: next cycle all outputs 0 with no done pulse; a subsequent start streams the frame from (0,0).
- Scenario 6, back-to-back frames.
  - Stimulus: start asserted in the DONE cycle, then again in IDLE.
  - Required response: the first start is ignored; the second starts a new frame with a valid snapshot, and sof is seen on its first pixel.
